// File: rtl/tx_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tx_fifo_ctrl
//   Transmit FIFO controller in front of an external 4096x8 LSRAM. It tracks
//   13-bit write/read pointers (12-bit address plus wrap bit), drives the
//   RAM write and read ports, and reports fill level and status flags.
//
//   Build option: define TX_FIFO_FWFT_EN for first-word-fall-through mode
//   (2-entry output buffer, registered Q). Without it the FIFO runs in
//   standard mode: Q is the RAM read data, valid the cycle after a pop.
//
// Ports
//   i_clk        single clock for all logic and both RAM ports
//   i_rst        asynchronous active-high reset
//   i_we/i_data  push request and data from the producer
//   i_re         pop request from the serializer
//   o_q/o_q_valid  pop data and its valid flag
//   o_full/o_empty/o_afull/o_aempty  status flags
//   o_wrcnt      words held (0..4096)
//   o_overflow/o_underflow  one-cycle error pulses
//   o_wd/o_waddr/o_wen      RAM write port
//   i_rd/o_raddr/o_ren      RAM read port (i_rd valid the cycle after o_ren)
// ---------------------------------------------------------------------------
module tx_fifo_ctrl #(
  parameter int AFULL_LVL  = 4032,
  parameter int AEMPTY_LVL = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_we,
  input  logic [7:0]  i_data,
  input  logic        i_re,
  output logic [7:0]  o_q,
  output logic        o_q_valid,
  output logic        o_full,
  output logic        o_empty,
  output logic        o_afull,
  output logic        o_aempty,
  output logic [12:0] o_wrcnt,
  output logic        o_overflow,
  output logic        o_underflow,
  output logic [7:0]  o_wd,
  output logic [11:0] o_waddr,
  output logic        o_wen,
  input  logic [7:0]  i_rd,
  output logic [11:0] o_raddr,
  output logic        o_ren
);

  localparam logic [12:0] DEPTH      = 13'd4096;
  localparam logic [12:0] AFULL_CNT  = 13'(AFULL_LVL);
  localparam logic [12:0] AEMPTY_CNT = 13'(AEMPTY_LVL);

  logic [12:0] r_wptr;
  logic [12:0] r_rptr;
  logic        r_overflow;
  logic        r_underflow;

  logic        w_push;      // accepted push this cycle
  logic        w_pop;       // accepted pop this cycle
  logic        w_rd_issue;  // RAM read issued this cycle
  logic [12:0] w_ram_cnt;   // words written but not yet read from RAM

  // Wrap bit makes the difference exact for 0..4096.
  assign w_ram_cnt = r_wptr - r_rptr;
  assign w_push    = i_we & ~o_full;

  // Pointers and error pulses
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + 13'd1;
      if (w_rd_issue)
        r_rptr <= r_rptr + 13'd1;
      r_overflow  <= i_we & o_full;
      r_underflow <= i_re & o_empty;
    end
  end

  // RAM ports; enables are held low while reset is asserted.
  assign o_wd    = i_data;
  assign o_waddr = r_wptr[11:0];
  assign o_wen   = w_push & ~i_rst;
  assign o_raddr = r_rptr[11:0];
  assign o_ren   = w_rd_issue & ~i_rst;

  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;

  // Flags decode registered state only.
  assign o_full   = (o_wrcnt == DEPTH);
  assign o_afull  = (o_wrcnt >= AFULL_CNT);
  assign o_aempty = (o_wrcnt <= AEMPTY_CNT);

`ifdef TX_FIFO_FWFT_EN
  // -------------------------------------------------------------------------
  // First-word-fall-through: RAM words are prefetched into a 2-entry buffer
  // whose head register is Q.
  // -------------------------------------------------------------------------
  logic [7:0] r_buf0;
  logic [7:0] r_buf1;
  logic [1:0] r_buf_cnt;
  logic       r_inflight;  // a RAM read whose data lands on the next edge
  logic [2:0] w_occ;

  assign o_empty = (r_buf_cnt == 2'd0);
  assign w_pop   = i_re & ~o_empty;

  // Buffer plus in-flight occupancy after this cycle's pop; keeping it below
  // two before issuing guarantees a landing read always finds a free slot.
  assign w_occ      = {1'b0, r_buf_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_rd_issue = (w_ram_cnt != 13'd0) && (w_occ < 3'd2);

  assign o_wrcnt   = w_ram_cnt + {11'd0, r_buf_cnt} + {12'd0, r_inflight};
  assign o_q       = r_buf0;
  assign o_q_valid = ~o_empty;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_buf0     <= '0;
      r_buf1     <= '0;
      r_buf_cnt  <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_rd_issue;
      case ({w_pop, r_inflight})
        2'b11: begin
          // Head leaves, RAM data enters behind whatever remains.
          if (r_buf_cnt == 2'd1) begin
            r_buf0 <= i_rd;
          end else begin
            r_buf0 <= r_buf1;
            r_buf1 <= i_rd;
          end
        end
        2'b10: begin
          r_buf0    <= r_buf1;
          r_buf_cnt <= r_buf_cnt - 2'd1;
        end
        2'b01: begin
          if (r_buf_cnt == 2'd0)
            r_buf0 <= i_rd;
          else
            r_buf1 <= i_rd;
          r_buf_cnt <= r_buf_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end
`else
  // -------------------------------------------------------------------------
  // Standard mode: a pop reads the RAM directly; Q is the RAM output.
  // -------------------------------------------------------------------------
  logic r_q_valid;

  assign o_empty    = (w_ram_cnt == 13'd0);
  assign w_pop      = i_re & ~o_empty;
  assign w_rd_issue = w_pop;
  assign o_wrcnt    = w_ram_cnt;
  assign o_q        = i_rd;
  assign o_q_valid  = r_q_valid;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_q_valid <= 1'b0;
    else
      r_q_valid <= w_pop;
  end
`endif

endmodule

// File: tb/tb_tx_fifo_ctrl.sv
module tb_tx_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [7:0]  data;
  logic        re;
  logic [7:0]  q;
  logic        q_valid;
  logic        full, empty, afull, aempty;
  logic [12:0] wrcnt;
  logic        overflow, underflow;
  logic [7:0]  wd;
  logic [11:0] waddr;
  logic        wen;
  logic [7:0]  rd;
  logic [11:0] raddr;
  logic        ren;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tx_fifo_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_we(we), .i_data(data), .i_re(re),
    .o_q(q), .o_q_valid(q_valid), .o_full(full), .o_empty(empty),
    .o_afull(afull), .o_aempty(aempty), .o_wrcnt(wrcnt),
    .o_overflow(overflow), .o_underflow(underflow),
    .o_wd(wd), .o_waddr(waddr), .o_wen(wen),
    .i_rd(rd), .o_raddr(raddr), .o_ren(ren)
  );

  // 4096x8 LSRAM model: synchronous write, registered read.
  logic [7:0] mem [0:4095];
  always @(posedge clk) begin
    if (wen) mem[waddr] <= wd;
    if (ren) rd <= mem[raddr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state();
    chk("rst_wrcnt", 32'(wrcnt), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_aempty", 32'(aempty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_afull", 32'(afull), 0);
    chk("rst_qvalid", 32'(q_valid), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_unf", 32'(underflow), 0);
    chk("rst_wen", 32'(wen), 0);
    chk("rst_ren", 32'(ren), 0);
    chk("rst_waddr", 32'(waddr), 0);
    chk("rst_raddr", 32'(raddr), 0);
`ifdef TX_FIFO_FWFT_EN
    chk("rst_q", 32'(q), 0);
`endif
  endtask

  typedef struct {
    logic        we;
    logic [7:0]  data;
    logic        re;
    logic        exp_wen;
    logic        exp_ren;
    logic [12:0] exp_cnt;
    logic        exp_empty;
    logic        exp_qv;
    logic [7:0]  exp_q;
    logic        exp_unf;
  } vec_t;

  initial begin : watchdog
    #3_000_000;
    n_bad++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t vecs[11];
    int bad;
    int exp_rd;
    int wval;
    logic [11:0] saved;

    rst = 1'b1; we = 1'b1; re = 1'b1; data = 8'hEE;
    tick(); tick();
    chk_reset_state();
    rst = 1'b0; we = 1'b0; re = 1'b0;

`ifndef TX_FIFO_FWFT_EN
    //           we  data   re  wen ren cnt    emp qv  q      unf
    vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 13'd1, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 13'd0, 1'b1, 1'b1, 8'hA5, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 13'd0, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 13'd0, 1'b1, 1'b0, 8'h00, 1'b1};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 13'd0, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[5]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 13'd1, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[6]  = '{1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 13'd1, 1'b0, 1'b1, 8'h11, 1'b0};
    vecs[7]  = '{1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 13'd1, 1'b0, 1'b1, 8'h22, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 13'd0, 1'b1, 1'b1, 8'h33, 1'b0};
    vecs[9]  = '{1'b1, 8'h44, 1'b1, 1'b1, 1'b0, 13'd1, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 13'd0, 1'b1, 1'b1, 8'h44, 1'b0};

    for (int i = 0; i < 11; i++) begin
      we = vecs[i].we; data = vecs[i].data; re = vecs[i].re;
      #1;
      chk($sformatf("v%0d_wen", i), 32'(wen), 32'(vecs[i].exp_wen));
      chk($sformatf("v%0d_ren", i), 32'(ren), 32'(vecs[i].exp_ren));
      tick();
      chk($sformatf("v%0d_cnt", i), 32'(wrcnt), 32'(vecs[i].exp_cnt));
      chk($sformatf("v%0d_empty", i), 32'(empty), 32'(vecs[i].exp_empty));
      chk($sformatf("v%0d_qv", i), 32'(q_valid), 32'(vecs[i].exp_qv));
      if (vecs[i].exp_qv)
        chk($sformatf("v%0d_q", i), 32'(q), 32'(vecs[i].exp_q));
      chk($sformatf("v%0d_unf", i), 32'(underflow), 32'(vecs[i].exp_unf));
      chk($sformatf("v%0d_ovf", i), 32'(overflow), 0);
      $display("vec %0d: we=%0b d=%02h re=%0b -> cnt=%0d empty=%0b qv=%0b q=%02h", i,
               vecs[i].we, vecs[i].data, vecs[i].re, wrcnt, empty, q_valid, q);
    end
    we = 1'b0; re = 1'b0;

    // Underflow leaves the read pointer alone.
    saved = raddr;
    re = 1'b1;
    #1;
    chk("unf_ren", 32'(ren), 0);
    tick();
    re = 1'b0;
    chk("unf_pulse", 32'(underflow), 1);
    chk("unf_raddr", 32'(raddr), 32'(saved));
    tick();
    chk("unf_clear", 32'(underflow), 0);

    // Fill to capacity with threshold boundaries.
    for (int i = 0; i < 4096; i++) begin
      we = 1'b1; data = 8'(i);
      tick();
      if (i == 63)   chk("aempty_at_64", 32'(aempty), 1);
      if (i == 64)   chk("aempty_at_65", 32'(aempty), 0);
      if (i == 4030) chk("afull_at_4031", 32'(afull), 0);
      if (i == 4031) chk("afull_at_4032", 32'(afull), 1);
      if (i == 4094) chk("full_at_4095", 32'(full), 0);
    end
    we = 1'b0;
    chk("fill_full", 32'(full), 1);
    chk("fill_cnt", 32'(wrcnt), 4096);
    $display("fill: 4096 words, full=%0b cnt=%0d", full, wrcnt);

    saved = waddr;
    we = 1'b1; data = 8'hFF;
    #1;
    chk("ovf_wen", 32'(wen), 0);
    tick();
    we = 1'b0;
    chk("ovf_pulse", 32'(overflow), 1);
    chk("ovf_waddr", 32'(waddr), 32'(saved));
    chk("ovf_cnt", 32'(wrcnt), 4096);
    tick();
    chk("ovf_clear", 32'(overflow), 0);

    bad = 0;
    for (int i = 0; i < 4096; i++) begin
      re = 1'b1;
      tick();
      if (!q_valid || q !== 8'(i)) bad++;
    end
    re = 1'b0;
    chk("drain_order_errors", 32'(bad), 0);
    chk("drain_empty", 32'(empty), 1);
    chk("drain_cnt", 32'(wrcnt), 0);
    $display("drain: 4096 words popped, order errors=%0d", bad);

    // Steady state at 4000 words across the address wrap.
    for (int i = 0; i < 4000; i++) begin
      we = 1'b1; data = 8'(i);
      tick();
    end
    exp_rd = 0; wval = 4000; bad = 0;
    for (int i = 0; i < 200; i++) begin
      we = 1'b1; re = 1'b1; data = 8'(wval);
      tick();
      wval++;
      if (wrcnt !== 13'd4000 || afull || overflow || underflow) bad++;
      if (!q_valid || q !== 8'(exp_rd)) bad++;
      exp_rd++;
    end
    we = 1'b0; re = 1'b0;
    chk("stream_errors", 32'(bad), 0);
    for (int i = 0; i < 4000; i++) begin
      re = 1'b1;
      tick();
      if (!q_valid || q !== 8'(exp_rd)) bad++;
      exp_rd++;
    end
    re = 1'b0;
    chk("stream_drain_errors", 32'(bad), 0);
    chk("stream_empty", 32'(empty), 1);
    $display("stream: 200 push+pop cycles at depth 4000, errors=%0d", bad);

    // Reset with 100 words queued and a read in flight.
    for (int i = 0; i < 100; i++) begin
      we = 1'b1; data = 8'(i + 128);
      tick();
    end
    we = 1'b0; re = 1'b1;
    tick();
    chk("mid_ren_active", 32'(ren), 1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_state();
    tick();
    rst = 1'b0; re = 1'b0;
    we = 1'b1; data = 8'h5A;
    tick();
    we = 1'b0; re = 1'b1;
    tick();
    re = 1'b0;
    chk("post_rst_qv", 32'(q_valid), 1);
    chk("post_rst_q", 32'(q), 32'h5A);
    chk("post_rst_empty", 32'(empty), 1);
    $display("reset mid-op: round trip q=%02h", q);
`else
    // First word falls through two edges after its write edge.
    we = 1'b1; data = 8'h3C;
    tick();
    we = 1'b0;
    chk("fw_n_qv", 32'(q_valid), 0);
    chk("fw_n_cnt", 32'(wrcnt), 1);
    tick();
    chk("fw_n1_qv", 32'(q_valid), 0);
    tick();
    chk("fw_n2_qv", 32'(q_valid), 1);
    chk("fw_n2_q", 32'(q), 32'h3C);
    chk("fw_n2_cnt", 32'(wrcnt), 1);
    $display("fwft: first word q=%02h qv=%0b", q, q_valid);
    re = 1'b1;
    tick();
    re = 1'b0;
    chk("fw_pop_empty", 32'(empty), 1);
    chk("fw_pop_cnt", 32'(wrcnt), 0);
    re = 1'b1;
    tick();
    re = 1'b0;
    chk("fw_unf", 32'(underflow), 1);

    for (int i = 0; i < 10; i++) begin
      we = 1'b1; data = 8'(8'h50 + i);
      tick();
    end
    we = 1'b0;
    tick(); tick(); tick();
    chk("fw_cnt10", 32'(wrcnt), 10);
    chk("fw_head", 32'(q), 32'h50);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      re = 1'b1;
      if (!q_valid || q !== 8'(8'h50 + i)) bad++;
      tick();
    end
    re = 1'b0;
    chk("fw_burst_errors", 32'(bad), 0);
    chk("fw_burst_empty", 32'(empty), 1);
    chk("fw_burst_cnt", 32'(wrcnt), 0);
    $display("fwft: 10-word burst errors=%0d", bad);

    for (int i = 0; i < 5; i++) begin
      we = 1'b1; data = 8'(i + 8'h90);
      tick();
    end
    we = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_reset_state();
    tick();
    rst = 1'b0;
    we = 1'b1; data = 8'h77;
    tick();
    we = 1'b0;
    tick(); tick();
    chk("fw_post_rst_q", 32'(q), 32'h77);
    chk("fw_post_rst_cnt", 32'(wrcnt), 1);
    $display("fwft reset mid-op: q=%02h cnt=%0d", q, wrcnt);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tx_fifo_ctrl.md
TX_FIFO_CTRL -- requirements
Module: tx_fifo_ctrl

Interface
REQ-001 Parameter AFULL_LVL, default 4032, almost-full threshold in words.
REQ-002 Parameter AEMPTY_LVL, default 64, almost-empty threshold in words.
REQ-003 CLK  input  1  single clock for all logic and both RAM ports.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 WE  input  1  push request from the EEPROM transmit producer.
REQ-006 DATA  input  8  push data.
REQ-007 RE  input  1  pop request from the downstream serializer.
REQ-008 Q  output  8  pop data.
REQ-009 Q_VALID  output  1  Q holds a valid word.
REQ-010 FULL, EMPTY, AFULL, AEMPTY  output  1 each  status flags.
REQ-011 WRCNT  output  13  words held, 0..4096.
REQ-012 OVERFLOW, UNDERFLOW  output  1 each  one-cycle error pulses.
REQ-013 WD  output  8, WADDR  output  12, WEN  output  1  write port of the 4096x8 LSRAM, active-high enable.
REQ-014 RD  input  8, RADDR  output  12, REN  output  1  read port of the LSRAM; RD is valid the cycle after REN is sampled high.

Function
REQ-015 Write and read pointers are 13 bits (12-bit address plus wrap bit); WADDR = wptr[11:0], RADDR = rptr[11:0]; both wrap 4095 -> 0.
REQ-016 Push accepted when WE=1 and FULL=0: WEN=1, WD=DATA, wptr increments at the same edge.
REQ-017 WE=1 with FULL=1: no RAM write, pointers unchanged, OVERFLOW=1 the following cycle.
REQ-018 FULL=1 when the count equals 4096; EMPTY=1 when no word is poppable; flags are derived from registered state, so a simultaneous pop does not admit a push while FULL=1.
REQ-019 AFULL=1 when WRCNT >= AFULL_LVL; AEMPTY=1 when WRCNT <= AEMPTY_LVL.
REQ-020 Simultaneous accepted push and pop leave WRCNT unchanged.
REQ-021 Standard mode: pop accepted when RE=1 and EMPTY=0; REN=1 and rptr increments at the same edge.
REQ-022 Standard mode: Q = RD; Q_VALID=1 exactly in the cycle after an accepted pop; WRCNT = wptr - rptr.
REQ-023 RE=1 with EMPTY=1: no RAM read, pointers unchanged, UNDERFLOW=1 the following cycle.
REQ-024 Sustained throughput is one push and one pop per cycle with no bubbles.

Reset
REQ-025 While RST=1, all of the following hold: pointers=0, WRCNT=0, EMPTY=1, AEMPTY=1, FULL=0, AFULL=0, Q_VALID=0, OVERFLOW=0, UNDERFLOW=0, WEN=0, REN=0, and Q=0 in FWFT mode.
REQ-026 Reset mid-operation discards all content, including in-flight reads; RAM contents are not cleared.
REQ-027 The first push is accepted on the first rising edge after RST falls.

Configuration
REQ-028 Macro TX_FIFO_FWFT_EN defined: first-word-fall-through mode using a 2-entry output buffer feeding a registered Q.
- Q_VALID = NOT EMPTY, where EMPTY means the buffer is empty.
- RE pops the head word.
- A RAM read issues when the RAM holds words and (buffer words + in-flight reads) stays < 2 after this cycle's pop.
- WRCNT counts RAM, in-flight and buffer words.
- The first word reaches Q 2 edges after its write edge.
REQ-029 Macro undefined: standard mode per REQ-021..REQ-022; no output buffer is instantiated.

Verification
REQ-030 Standard mode, reset; push 0xA5; pop the next cycle -> Q=0xA5 with Q_VALID=1 one cycle later; EMPTY=1, WRCNT=0.
REQ-031 Push 4096 incrementing bytes -> FULL=1 and WRCNT=4096; a 4097th push -> OVERFLOW pulse, no pointer change; pop all -> data 0x00..0xFF repeating, in order.
REQ-032 Fill to 4000, then push and pop every cycle for 200 cycles across the 4095->0 wrap -> WRCNT stays 4000; AFULL=0 throughout; no errors; data ordered.
REQ-033 RE=1 while EMPTY=1 -> UNDERFLOW pulse, REN=0, rptr unchanged.
REQ-034 FWFT build, push 0x3C at edge N -> Q=0x3C and Q_VALID=1 after edge N+2; RE held for 10 words -> one word per cycle.
REQ-035 Assert RST with 100 words queued and a read in flight -> all outputs reach their reset values immediately; the next push/pop round-trip returns the new data only.
